// File: rtl/spin_speed_pkg.sv
//------------------------------------------------------------------------------
// Module   : spin_speed_pkg
// Brief    : Wash-mode encodings and per-mode spin tables for the speed selector.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spin_speed_pkg;

  localparam logic [2:0] MODE_COTTON     = 3'd0;
  localparam logic [2:0] MODE_SYNTHETICS = 3'd1;
  localparam logic [2:0] MODE_DRUM_CLEAN = 3'd2;
  localparam logic [2:0] MODE_QUICK      = 3'd3;
  localparam logic [2:0] MODE_DAILY      = 3'd4;
  localparam logic [2:0] MODE_DELICATES  = 3'd5;
  localparam logic [2:0] MODE_WOOL       = 3'd6;
  localparam logic [2:0] MODE_COLOURS    = 3'd7;

  // Unclamped table values; the selector clamps them to its own level count.
  function automatic int unsigned max_level(input int unsigned mode);
    case (mode)
      32'(MODE_COTTON):     return 6;
      32'(MODE_SYNTHETICS): return 5;
      32'(MODE_DRUM_CLEAN): return 5;
      32'(MODE_QUICK):      return 3;
      32'(MODE_DAILY):      return 6;
      32'(MODE_DELICATES):  return 2;
      32'(MODE_WOOL):       return 3;
      default:              return 6;
    endcase
  endfunction

  function automatic int unsigned default_level(input int unsigned mode);
    case (mode)
      32'(MODE_COTTON):     return 6;
      32'(MODE_SYNTHETICS): return 5;
      32'(MODE_DRUM_CLEAN): return 5;
      32'(MODE_QUICK):      return 3;
      32'(MODE_DAILY):      return 6;
      32'(MODE_DELICATES):  return 1;
      32'(MODE_WOOL):       return 3;
      default:              return 6;
    endcase
  endfunction

  function automatic int unsigned level_to_rpm(input int unsigned lvl,
                                               input int unsigned base_rpm,
                                               input int unsigned step_rpm);
    if (lvl == 0) return 0;
    return base_rpm + (lvl - 1) * step_rpm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spin_speed_selector_param_btn_rise_detect.sv
//------------------------------------------------------------------------------
// Module   : btn_rise_detect
// Brief    : Registers a debounced button level and flags its rising edge.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise
);

  logic btn_d;
  logic btn_q;

  always_comb begin
    btn_d = btn;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign rise = btn & ~btn_q;

endmodule

`default_nettype wire

// File: rtl/spin_speed_selector_param.sv
//------------------------------------------------------------------------------
// Module   : spin_speed_selector_param
// Brief    : Per-mode spin level selector with lock, wrap/saturate and rpm out.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spin_speed_selector_param
  import spin_speed_pkg::*;
#(
  parameter int NUM_LEVELS = 7,
  parameter int SPEED_W    = 11,
  parameter int SPEED_BASE = 400,
  parameter int SPEED_STEP = 200,
  parameter int MODE_W     = 3,
  parameter int WRAP       = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [MODE_W-1:0]             wash_mode,
  input  logic                          lock,
  input  logic                          up_btn,
  input  logic                          down_btn,
  output logic [$clog2(NUM_LEVELS)-1:0] level,
  output logic [SPEED_W-1:0]            spin_speed,
  output logic                          changed,
  output logic                          limit_hit
);

  localparam int          LVL_W   = $clog2(NUM_LEVELS);
  localparam int          PROD_W  = SPEED_W + LVL_W;
  localparam int unsigned TOP_LVL = 32'(NUM_LEVELS - 1);
  localparam longint      MAX_RPM = longint'(SPEED_BASE) +
                                    longint'(NUM_LEVELS - 2) * longint'(SPEED_STEP);

  generate
    if (MAX_RPM >= (longint'(1) <<< SPEED_W)) begin : g_rpm_range_err
      $error("spin_speed_selector_param: top rpm does not fit in SPEED_W bits");
    end
  endgenerate

  function automatic logic [LVL_W-1:0] clamp_lvl(input int unsigned v);
    return (v > TOP_LVL) ? LVL_W'(TOP_LVL) : LVL_W'(v);
  endfunction

  logic up_rise;
  logic down_rise;

  btn_rise_detect u_up_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (up_btn),
    .rise    (up_rise)
  );

  btn_rise_detect u_down_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (down_btn),
    .rise    (down_rise)
  );

  logic [LVL_W-1:0]   level_q,        level_d;
  logic [SPEED_W-1:0] spin_speed_q,   spin_speed_d;
  logic               changed_q,      changed_d;
  logic               limit_hit_q,    limit_hit_d;
  logic [MODE_W-1:0]  mode_q,         mode_d;
  logic               init_pending_q, init_pending_d;

  logic [LVL_W-1:0] maxl_cur;
  logic [LVL_W-1:0] defl_new;

  assign maxl_cur = clamp_lvl(max_level(32'(mode_q)));
  assign defl_new = clamp_lvl(default_level(32'(wash_mode)));

  always_comb begin
    level_d        = level_q;
    mode_d         = mode_q;
    init_pending_d = init_pending_q;
    limit_hit_d    = 1'b0;

    if (!lock) begin
      // A mode (re)load swallows any button edge arriving in the same cycle.
      if (init_pending_q || (wash_mode != mode_q)) begin
        level_d        = defl_new;
        mode_d         = wash_mode;
        init_pending_d = 1'b0;
      end else if (up_rise && down_rise) begin
        level_d = level_q;
      end else if (up_rise) begin
        if (level_q < maxl_cur) begin
          level_d = level_q + LVL_W'(1);
        end else if (WRAP != 0) begin
          level_d = '0;
        end else begin
          limit_hit_d = 1'b1;
        end
      end else if (down_rise) begin
        if (level_q != '0) begin
          level_d = level_q - LVL_W'(1);
        end else if (WRAP != 0) begin
          level_d = maxl_cur;
        end else begin
          limit_hit_d = 1'b1;
        end
      end
    end

    changed_d    = (level_d != level_q);
    spin_speed_d = SPEED_W'(PROD_W'(level_to_rpm(32'(level_d), 32'(SPEED_BASE),
                                                 32'(SPEED_STEP))));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q        <= '0;
      spin_speed_q   <= '0;
      changed_q      <= 1'b0;
      limit_hit_q    <= 1'b0;
      mode_q         <= '0;
      init_pending_q <= 1'b1;
    end else begin
      level_q        <= level_d;
      spin_speed_q   <= spin_speed_d;
      changed_q      <= changed_d;
      limit_hit_q    <= limit_hit_d;
      mode_q         <= mode_d;
      init_pending_q <= init_pending_d;
    end
  end

  assign level      = level_q;
  assign spin_speed = spin_speed_q;
  assign changed    = changed_q;
  assign limit_hit  = limit_hit_q;

endmodule

`default_nettype wire

// File: tb/tb_spin_speed_selector_param.sv
//------------------------------------------------------------------------------
// Module   : tb_spin_speed_selector_param
// Brief    : Bench for the spin selector; wrapping and saturating instances.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spin_speed_selector_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lock;
  logic        up_btn;
  logic        down_btn;
  logic [2:0]  wash_mode;

  logic [2:0]  level_w,  level_s;
  logic [10:0] spd_w,    spd_s;
  logic        chg_w,    chg_s;
  logic        lim_w,    lim_s;

  always #5 clk = ~clk;

  spin_speed_selector_param #(.WRAP(1)) u_dut_wrap (
    .clk        (clk),
    .reset_n    (reset_n),
    .wash_mode  (wash_mode),
    .lock       (lock),
    .up_btn     (up_btn),
    .down_btn   (down_btn),
    .level      (level_w),
    .spin_speed (spd_w),
    .changed    (chg_w),
    .limit_hit  (lim_w)
  );

  spin_speed_selector_param #(.WRAP(0)) u_dut_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .wash_mode  (wash_mode),
    .lock       (lock),
    .up_btn     (up_btn),
    .down_btn   (down_btn),
    .level      (level_s),
    .spin_speed (spd_s),
    .changed    (chg_s),
    .limit_hit  (lim_s)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int maxl_t [8] = '{6, 5, 5, 3, 6, 2, 3, 6};
  int defl_t [8] = '{6, 5, 5, 3, 6, 1, 3, 6};

  // Reference state: index 0 = wrapping instance, index 1 = saturating.
  int m_lvl [2];
  bit m_chg [2];
  bit m_lim [2];
  bit m_up_q, m_dn_q, m_init;
  int m_mode;

  function automatic int rpm(input int l);
    return (l == 0) ? 0 : 400 + (l - 1) * 200;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_lvl[w] = 0;
      m_chg[w] = 1'b0;
      m_lim[w] = 1'b0;
    end
    m_up_q = 1'b0;
    m_dn_q = 1'b0;
    m_mode = 0;
    m_init = 1'b1;
  endtask

  task automatic model_edge();
    bit ue, de, reload;
    int old;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ue     = up_btn && !m_up_q;
    de     = down_btn && !m_dn_q;
    m_up_q = up_btn;
    m_dn_q = down_btn;
    reload = !lock && (m_init || (int'(wash_mode) != m_mode));
    for (int w = 0; w < 2; w++) begin
      old      = m_lvl[w];
      m_lim[w] = 1'b0;
      if (!lock) begin
        if (reload) begin
          m_lvl[w] = defl_t[wash_mode];
        end else if (ue && de) begin
          m_lvl[w] = old;
        end else if (ue) begin
          if (m_lvl[w] < maxl_t[m_mode]) m_lvl[w] = m_lvl[w] + 1;
          else if (w == 0)               m_lvl[w] = 0;
          else                           m_lim[w] = 1'b1;
        end else if (de) begin
          if (m_lvl[w] > 0)  m_lvl[w] = m_lvl[w] - 1;
          else if (w == 0)   m_lvl[w] = maxl_t[m_mode];
          else               m_lim[w] = 1'b1;
        end
      end
      m_chg[w] = (m_lvl[w] != old);
    end
    if (reload) begin
      m_mode = int'(wash_mode);
      m_init = 1'b0;
    end
  endtask

  task automatic check_all();
    check("wrap_level",   32'(level_w), 32'(m_lvl[0]));
    check("wrap_rpm",     32'(spd_w),   32'(rpm(m_lvl[0])));
    check("wrap_changed", 32'(chg_w),   32'(m_chg[0]));
    check("wrap_limit",   32'(lim_w),   32'(m_lim[0]));
    check("sat_level",    32'(level_s), 32'(m_lvl[1]));
    check("sat_rpm",      32'(spd_s),   32'(rpm(m_lvl[1])));
    check("sat_changed",  32'(chg_s),   32'(m_chg[1]));
    check("sat_limit",    32'(lim_s),   32'(m_lim[1]));
  endtask

  task automatic step(input bit l, input int mode, input bit u, input bit d);
    lock      = l;
    wash_mode = 3'(mode);
    up_btn    = u;
    down_btn  = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int cur_mode;
    reset_n   = 1'b0;
    lock      = 1'b0;
    wash_mode = 3'd0;
    up_btn    = 1'b0;
    down_btn  = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // Power-up default load for cotton
    step(0, 0, 0, 0);
    check("pwrup_rpm", 32'(spd_w), 32'd1400);
    step(0, 0, 0, 0);

    // Delicates: wrap over the top and back under the bottom
    step(0, 5, 0, 0);
    step(0, 5, 1, 0);
    step(0, 5, 0, 0);
    step(0, 5, 1, 0);
    step(0, 5, 0, 0);
    step(0, 5, 0, 1);
    check("deli_wrap_down_rpm", 32'(spd_w), 32'd600);
    step(0, 5, 0, 0);

    // Quick: saturating instance clamps at its ceiling
    step(0, 3, 0, 0);
    step(0, 3, 1, 0);
    check("quick_limit", 32'(lim_s), 32'd1);
    step(0, 3, 0, 0);

    // Lock freezes buttons and mode changes; held button does not fire later
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 6, 0, 0);
    step(1, 6, 1, 0);
    step(0, 6, 1, 0);
    check("unlock_rpm", 32'(spd_w), 32'd800);
    step(0, 6, 1, 0);
    step(0, 6, 0, 0);

    // Simultaneous rising edges cancel
    step(0, 6, 1, 1);
    step(0, 6, 0, 0);

    // Asynchronous reset mid-cycle, then default reload for the current mode
    step(0, 6, 1, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    step(0, 6, 0, 0);
    reset_n = 1'b1;
    step(0, 6, 0, 0);
    check("post_reset_level", 32'(level_w), 32'd3);

    cur_mode = 6;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) cur_mode = int'($urandom_range(0, 7));
      step(($urandom_range(0, 3) == 0), cur_mode,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
